// File: rtl/fifo_pkg.sv
// Shared types for the FIFO drain / UART transmit path.
//   tx_state_t : transmitter FSM states
//   frame_bits : line bits per frame (start + data + optional parity + stop)
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int frame_bits(input int data_w, input int parity_en);
        return 2 + data_w + parity_en;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the synchronous FIFO and its drain logic.
//   empty_i    : FIFO empty flag
//   pop_o      : pop strobe, one cycle per word
//   pop_data_i : head word, valid while empty_i=0 (first-word-fall-through)
// master = the drain side (fifo_uart_tx), slave = the FIFO side.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              empty_i;
    logic              pop_o;
    logic [DATA_W-1:0] pop_data_i;

    modport master (output pop_o, input empty_i, input pop_data_i);
    modport slave  (input pop_o, output empty_i, output pop_data_i);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   restart    : hold the count at the start of a bit period
//   bit_end    : high on the final cycle of each CLKS_PER_BIT-cycle period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_end = (r_cnt == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO onto a UART line:
// start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
//   clk, reset : clock, asynchronous active-high reset
//   enable_i   : permission to start new frames
//   fifo       : FIFO read port (empty_i, pop_o, pop_data_i)
//   tx_o       : serial line, idle high
//   busy_o     : frame in progress
//   done_o     : pulse in the last cycle of each stop bit
//
// state  | meaning
// IDLE   | line high, waiting for enable_i with a word available
// START  | driving the start bit (0)
// DATA   | driving data bit r_bit_cnt
// PARITY | driving even parity of the word (only when PARITY_EN=1)
// STOP   | driving the stop bit (1); may pop the next word on its last cycle
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_tx;
    logic              r_busy;

    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_pop;
    logic [DATA_W-1:0] w_shift_next;

    // Counter is held at zero while idle so a pop from IDLE starts a full
    // start-bit period; from STOP it wraps on its own at the period end.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(r_state == IDLE),
        .bit_end(w_bit_end)
    );

    assign w_last_stop  = (r_state == STOP) && w_bit_end;
    // reset term keeps the strobe quiet while the FSM is forced to IDLE.
    assign w_pop        = enable_i && !fifo.empty_i && !reset &&
                          ((r_state == IDLE) || w_last_stop);
    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_pop) begin
            // Head word is sampled in the same cycle the pop is issued.
            r_state   <= START;
            r_shift   <= fifo.pop_data_i;
            r_parity  <= ^fifo.pop_data_i;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else if (w_bit_end) begin
            case (r_state)
                START: begin
                    r_state   <= DATA;
                    r_bit_cnt <= '0;
                    r_tx      <= r_shift[0];
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            r_state <= PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        r_shift   <= w_shift_next;
                        r_tx      <= w_shift_next[0];
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
                STOP: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.pop_o = w_pop;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;
    assign done_o     = w_last_stop;
endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;
    import fifo_pkg::*;

    localparam int CA = 4;
    localparam int NA = frame_bits(8, 1);
    localparam int CB = 1;
    localparam int NB = frame_bits(1, 0);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_req = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1;
    logic en_drv_a = 1'b1, en_drv_b = 1'b1;
    logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

    fifo_uart_tx_if #(.DATA_W(8)) ifa ();
    fifo_uart_tx_if #(.DATA_W(1)) ifb ();

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CA), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(reset), .enable_i(en_drv_a), .fifo(ifa.master),
        .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a));

    fifo_uart_tx #(.DATA_W(1), .CLKS_PER_BIT(CB), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(reset), .enable_i(en_drv_b), .fifo(ifb.master),
        .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b));

    always #5 clk = ~clk;

    // FIFO contents and reference model state
    logic [7:0] q_a[$];
    logic       q_b[$];
    bit         ma_act, mb_act;
    int         ma_t, mb_t;
    logic [NA-1:0] ma_frame;
    logic [NB-1:0] mb_frame;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic s_tx_a, s_pop_a, s_done_a, s_busy_a, s_tx_b, s_pop_b;

    typedef struct {
        logic [7:0]    data;
        logic [NA-1:0] frame;   // bit i = line level during frame bit i
    } vec_t;
    vec_t tbl[6];

    function automatic logic [NA-1:0] build_a(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    function automatic logic [NB-1:0] build_b(input logic d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, compare both DUTs
    // against the model, then advance the model to the next rising edge.
    task automatic step();
        bit last_a, last_b, ep_a, ep_b;
        @(negedge clk);
        reset    = rst_req;
        en_drv_a = en_a;
        en_drv_b = en_b;
        ifa.empty_i    = (q_a.size() == 0);
        ifa.pop_data_i = (q_a.size() != 0) ? q_a[0] : 8'($urandom);
        ifb.empty_i    = (q_b.size() == 0);
        ifb.pop_data_i = (q_b.size() != 0) ? q_b[0] : 1'($urandom);
        #1;
        cyc++;
        if (reset) begin
            ma_act = 0;
            mb_act = 0;
        end
        last_a = ma_act && (ma_t == CA * NA - 1);
        last_b = mb_act && (mb_t == CB * NB - 1);
        ep_a = !reset && en_drv_a && (q_a.size() != 0) && (!ma_act || last_a);
        ep_b = !reset && en_drv_b && (q_b.size() != 0) && (!mb_act || last_b);

        chk("a_tx",   tx_a,      ma_act ? ma_frame[ma_t / CA] : 1'b1);
        chk("a_busy", busy_a,    ma_act);
        chk("a_done", done_a,    last_a);
        chk("a_pop",  ifa.pop_o, ep_a);
        chk("b_tx",   tx_b,      mb_act ? mb_frame[mb_t / CB] : 1'b1);
        chk("b_busy", busy_b,    mb_act);
        chk("b_done", done_b,    last_b);
        chk("b_pop",  ifb.pop_o, ep_b);

        s_tx_a = tx_a; s_pop_a = ifa.pop_o; s_done_a = done_a; s_busy_a = busy_a;
        s_tx_b = tx_b; s_pop_b = ifb.pop_o;

        if (ep_a) begin
            ma_frame = build_a(q_a.pop_front());
            ma_t = 0;
            ma_act = 1;
        end else if (ma_act) begin
            if (last_a) ma_act = 0;
            else ma_t++;
        end
        if (ep_b) begin
            mb_frame = build_b(q_b.pop_front());
            mb_t = 0;
            mb_act = 1;
        end else if (mb_act) begin
            if (last_b) mb_act = 0;
            else mb_t++;
        end
    endtask

    task automatic wait_pop_a();
        int k = 0;
        step();
        while (!s_pop_a && k < 60) begin
            step();
            k++;
        end
        chk("a_pop_seen", s_pop_a, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        int pcyc[3];
        logic [5:0] seq_b;
        int k;

        tbl[0] = '{8'hA5, 11'h54A};
        tbl[1] = '{8'h01, 11'h602};
        tbl[2] = '{8'hFF, 11'h5FE};
        tbl[3] = '{8'h80, 11'h700};
        tbl[4] = '{8'h00, 11'h400};
        tbl[5] = '{8'h3C, 11'h478};

        ifa.empty_i = 1'b1; ifa.pop_data_i = '0;
        ifb.empty_i = 1'b1; ifb.pop_data_i = '0;

        // reset state, then idle line with empty FIFO
        repeat (3) step();
        rst_req = 1'b0;
        repeat (50) step();

        // single-frame table: line level mid-bit against hand-derived frames
        for (int e = 0; e < 6; e++) begin
            q_a.push_back(tbl[e].data);
            wait_pop_a();
            for (int i = 0; i < NA; i++) begin
                for (int j = 0; j < CA; j++) begin
                    step();
                    if (j == 1) chk($sformatf("tbl%0d_bit%0d", e, i), s_tx_a, tbl[e].frame[i]);
                end
            end
            chk($sformatf("tbl%0d_done", e), s_done_a, 1'b1);
            step();
            chk($sformatf("tbl%0d_idle", e), s_busy_a, 1'b0);
        end

        // streaming: pops exactly one frame apart
        q_a.push_back(8'h01); q_a.push_back(8'hFF); q_a.push_back(8'h80);
        np = 0;
        for (int i = 0; i < 200 && np < 3; i++) begin
            step();
            if (s_pop_a) begin
                pcyc[np] = cyc;
                np++;
            end
        end
        chk_int("stream_pops", np, 3);
        if (np == 3) begin
            chk_int("stream_gap1", pcyc[1] - pcyc[0], CA * NA);
            chk_int("stream_gap2", pcyc[2] - pcyc[1], CA * NA);
        end
        repeat (60) step();

        // enable dropped in data bit 3 with two words still queued
        q_a.push_back(8'h3C); q_a.push_back(8'hC1); q_a.push_back(8'h7E);
        wait_pop_a();
        repeat (17) step();
        en_a = 1'b0;
        k = 0;
        step();
        while (!s_done_a && k < 60) begin
            step();
            k++;
        end
        chk("gate_done_seen", s_done_a, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("gate_no_pop", s_pop_a, 1'b0);
            chk("gate_line_high", s_tx_a, 1'b1);
        end
        en_a = 1'b1;
        step();
        chk("reen_pop", s_pop_a, 1'b1);
        step();
        chk("reen_start", s_tx_a, 1'b0);
        repeat (100) step();

        // reset in data bit 5: line high without a clock edge, next word follows
        q_a.push_back(8'h5A); q_a.push_back(8'hC3);
        wait_pop_a();
        repeat (26) step();
        rst_req = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_pop", ifa.pop_o, 1'b0);
        repeat (2) step();
        rst_req = 1'b0;
        wait_pop_a();
        chk_int("rst_queue_left", q_a.size(), 0);
        repeat (50) step();

        // one-bit, one-clock corner: words 1,0 back to back
        q_b.push_back(1'b1); q_b.push_back(1'b0);
        seq_b = 6'b100110;
        step();
        chk("b_pop_c0", s_pop_b, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("b_seq%0d", i), s_tx_b, seq_b[i-1]);
            chk($sformatf("b_pop%0d", i), s_pop_b, (i == 3));
        end

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0 && q_a.size() < 4) q_a.push_back(8'($urandom));
            if ($urandom_range(2) == 0 && q_b.size() < 4) q_b.push_back(1'($urandom));
            if ($urandom_range(39) == 0) en_a = ~en_a;
            if ($urandom_range(29) == 0) en_b = ~en_b;
            step();
        end

        // drain
        en_a = 1'b1;
        en_b = 1'b1;
        k = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || ma_act || mb_act) && k < 600) begin
            step();
            k++;
        end
        chk("drain_complete", (q_a.size() == 0 && !ma_act && q_b.size() == 0 && !mb_act), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
